// File: rtl/poly_mac_schb_param_pkg.sv
// -----------------------------------------------------------------------------
// poly_mac_schb_param_pkg
// Shared definitions for the parametrised schoolbook negacyclic multiplier:
// host address region codes, FSM state encoding and a constant log2 helper
// used to size the address and counter fields.
// -----------------------------------------------------------------------------
package poly_mac_schb_param_pkg;

    // Upper two address bits select which coefficient memory is addressed.
    typedef enum logic [1:0] {
        REG_A    = 2'b00,
        REG_B    = 2'b01,
        REG_C    = 2'b10,
        REG_RSVD = 2'b11
    } region_e;

    typedef enum logic [1:0] {
        S_IDLE,
        S_CLEAR,
        S_MAC,
        S_FIN
    } state_e;

    // Ceiling log2, evaluated at elaboration time.
    function automatic int log2_f(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) begin
            r = r + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/schb_mac_unit.sv
// -----------------------------------------------------------------------------
// schb_mac_unit
// Combinational multiply-accumulate step of the schoolbook multiplier:
//   c_new_o = c_i + sext(a_i) * b_i        (negate_i = 0)
//   c_new_o = c_i - sext(a_i) * b_i        (negate_i = 1)
// all modulo 2^QW.
// Ports:
//   a_i      [SW-1:0]  secret coefficient, two's complement
//   b_i      [QW-1:0]  public coefficient, unsigned
//   c_i      [QW-1:0]  current accumulator coefficient
//   negate_i           subtract instead of add (negacyclic wrap term)
//   c_new_o  [QW-1:0]  updated accumulator coefficient
// -----------------------------------------------------------------------------
module schb_mac_unit #(
    parameter int QW = 13,
    parameter int SW = 4
) (
    input  logic [SW-1:0] a_i,
    input  logic [QW-1:0] b_i,
    input  logic [QW-1:0] c_i,
    input  logic          negate_i,
    output logic [QW-1:0] c_new_o
);

    logic [QW-1:0] a_ext;
    logic [QW-1:0] prod;

    // The low QW bits of the full SW+QW-bit signed product equal the product
    // of the sign-extended operands taken mod 2^QW, so only those bits are
    // formed; everything downstream is mod 2^QW anyway.
    assign a_ext   = QW'($signed(a_i));
    assign prod    = a_ext * b_i;
    assign c_new_o = negate_i ? (c_i - prod) : (c_i + prod);

endmodule

// File: rtl/poly_mac_schb_param.sv
// -----------------------------------------------------------------------------
// poly_mac_schb_param
// Memory-mapped negacyclic polynomial multiplier: C = A*B mod (x^N+1, 2^QW),
// one multiply-accumulate per cycle. mode selects overwrite (C cleared
// first) or accumulate (C += A*B).
// Ports:
//   clk       rising-edge clock
//   resetn    synchronous active-low reset
//   start     begin an operation (honoured in IDLE only)
//   mode      0 = overwrite, 1 = accumulate; sampled with start
//   address   [AW-1:AW-2] region (A/B/C/reserved), [AW-3:0] coefficient index
//   data_in   host write data
//   write_en  host write strobe (honoured in IDLE only)
//   data_out  registered read data: C[index] in IDLE for region C, else 0
//   busy      high during CLEAR and MAC
//   done      one-cycle completion pulse
// -----------------------------------------------------------------------------
module poly_mac_schb_param
    import poly_mac_schb_param_pkg::*;
#(
    parameter  int N  = 64,
    parameter  int QW = 13,
    parameter  int SW = 4,
    parameter  int DW = 16,
    localparam int AW = log2_f(N) + 2
) (
    input  logic          clk,
    input  logic          resetn,
    input  logic          start,
    input  logic          mode,
    input  logic [AW-1:0] address,
    input  logic [DW-1:0] data_in,
    input  logic          write_en,
    output logic [DW-1:0] data_out,
    output logic          busy,
    output logic          done
);

    localparam int LW = AW - 2;

    // NOTE: coefficient memories have no reset; a reset must not disturb the
    // loaded operands, and leaving them unreset lets them map onto RAM.
    logic [SW-1:0] mem_a [N];
    logic [QW-1:0] mem_b [N];
    logic [QW-1:0] mem_c [N];

    state_e        state_q;
    logic [LW-1:0] i_q;
    logic [LW-1:0] j_q;
    logic          busy_q;
    logic          done_q;
    logic [DW-1:0] data_out_q;

    region_e       region;
    logic [LW-1:0] idx;
    logic          host_we;
    logic [LW:0]   ij_sum;
    logic [LW-1:0] k;
    logic          wrap;
    logic [QW-1:0] c_new;
    logic [DW-1:0] rd_data_d;
    logic          unused_data;

    assign region  = region_e'(address[AW-1:AW-2]);
    assign idx     = address[AW-3:0];
    assign host_we = write_en && (state_q == S_IDLE);

    // k = (i+j) mod N; the carry out of the sum marks the x^N wrap, where
    // x^N = -1 turns the accumulation into a subtraction.
    assign ij_sum = {1'b0, i_q} + {1'b0, j_q};
    assign k      = ij_sum[LW-1:0];
    assign wrap   = ij_sum[LW];

    // Only the low QW bits of the host bus carry coefficient data.
    assign unused_data = ^data_in;

    schb_mac_unit #(
        .QW (QW),
        .SW (SW)
    ) u_mac (
        .a_i      (mem_a[i_q]),
        .b_i      (mem_b[j_q]),
        .c_i      (mem_c[k]),
        .negate_i (wrap),
        .c_new_o  (c_new)
    );

    // NOTE: every variable assigned in always_comb gets a default first so no
    // path leaves it holding its old value, which would infer a latch.
    always_comb begin
        rd_data_d = '0;
        if (state_q == S_IDLE && region == REG_C) begin
            rd_data_d = DW'(mem_c[idx]);
        end
    end

    // Memory write port: host writes in IDLE, clearing in CLEAR, the
    // read-modify-write of C[k] in MAC. Writes are suppressed during reset
    // so an abort leaves C exactly as the last completed MAC step left it.
    always_ff @(posedge clk) begin
        if (resetn) begin
            if (host_we) begin
                case (region)
                    REG_A:   mem_a[idx] <= data_in[SW-1:0];
                    REG_B:   mem_b[idx] <= data_in[QW-1:0];
                    REG_C:   mem_c[idx] <= data_in[QW-1:0];
                    default: ;
                endcase
            end
            if (state_q == S_CLEAR) begin
                mem_c[j_q] <= '0;
            end else if (state_q == S_MAC) begin
                mem_c[k] <= c_new;
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples values from before the edge regardless of order.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q    <= S_IDLE;
            i_q        <= '0;
            j_q        <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            data_out_q <= '0;
        end else begin
            done_q     <= 1'b0;
            data_out_q <= rd_data_d;
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        i_q     <= '0;
                        j_q     <= '0;
                        busy_q  <= 1'b1;
                        state_q <= mode ? S_MAC : S_CLEAR;
                    end
                end
                S_CLEAR: begin
                    // j doubles as the clear index.
                    j_q <= j_q + LW'(1);
                    if (j_q == LW'(N - 1)) begin
                        state_q <= S_MAC;
                    end
                end
                S_MAC: begin
                    // j wraps naturally at N because N is a power of two.
                    j_q <= j_q + LW'(1);
                    if (j_q == LW'(N - 1)) begin
                        i_q <= i_q + LW'(1);
                        if (i_q == LW'(N - 1)) begin
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                            state_q <= S_FIN;
                        end
                    end
                end
                S_FIN: begin
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign data_out = data_out_q;
    assign busy     = busy_q;
    assign done     = done_q;

endmodule

// File: tb/tb_poly_mac_schb_param.sv
// -----------------------------------------------------------------------------
// tb_poly_mac_schb_param
// Directed bench for poly_mac_schb_param with N = 4, QW = 13, SW = 4, DW = 16.
// Expected coefficients are hand-computed negacyclic products mod 2^13.
// -----------------------------------------------------------------------------
module tb_poly_mac_schb_param;

    logic        clk;
    logic        resetn;
    logic        start;
    logic        mode;
    logic [3:0]  address;
    logic [15:0] data_in;
    logic        write_en;
    logic [15:0] data_out;
    logic        busy;
    logic        done;

    int checks = 0;
    int errors = 0;

    poly_mac_schb_param #(
        .N  (4),
        .QW (13),
        .SW (4),
        .DW (16)
    ) dut (
        .clk      (clk),
        .resetn   (resetn),
        .start    (start),
        .mode     (mode),
        .address  (address),
        .data_in  (data_in),
        .write_en (write_en),
        .data_out (data_out),
        .busy     (busy),
        .done     (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic wr(input logic [1:0] rg, input logic [1:0] idx, input logic [15:0] d);
        @(negedge clk);
        address  = {rg, idx};
        data_in  = d;
        write_en = 1'b1;
        @(negedge clk);
        write_en = 1'b0;
    endtask

    task automatic rd(input logic [1:0] rg, input logic [1:0] idx, output logic [15:0] v);
        @(negedge clk);
        address = {rg, idx};
        @(negedge clk);
        v = data_out;
    endtask

    task automatic load4(input logic [1:0] rg, input logic [15:0] d0, input logic [15:0] d1,
                         input logic [15:0] d2, input logic [15:0] d3);
        wr(rg, 2'd0, d0);
        wr(rg, 2'd1, d1);
        wr(rg, 2'd2, d2);
        wr(rg, 2'd3, d3);
    endtask

    task automatic check_c(input string tag, input logic [15:0] e0, input logic [15:0] e1,
                           input logic [15:0] e2, input logic [15:0] e3);
        logic [15:0] v;
        rd(2'b10, 2'd0, v); check({tag, " C[0]"}, 32'(v), 32'(e0));
        rd(2'b10, 2'd1, v); check({tag, " C[1]"}, 32'(v), 32'(e1));
        rd(2'b10, 2'd2, v); check({tag, " C[2]"}, 32'(v), 32'(e2));
        rd(2'b10, 2'd3, v); check({tag, " C[3]"}, 32'(v), 32'(e3));
    endtask

    // Starts an operation and watches a fixed 60-cycle window. Cycle 1 is the
    // cycle right after the edge that samples start. With inject set, a start
    // pulse plus a write of 3 to A[0] land mid-MAC (i=0, j=1), and data_out
    // is checked to be 0 while busy even though region C is addressed.
    task automatic run(input logic m, input bit inject,
                       output int first_done, output int busy_cnt, output int done_cnt);
        @(negedge clk);
        start = 1'b1;
        mode  = m;
        @(posedge clk);
        #1;
        start      = 1'b0;
        first_done = 0;
        busy_cnt   = 0;
        done_cnt   = 0;
        for (int t = 1; t <= 60; t++) begin
            if (busy) busy_cnt++;
            if (done) begin
                done_cnt++;
                if (first_done == 0) first_done = t;
            end
            if (inject) begin
                if (t == 6) begin
                    start    = 1'b1;
                    mode     = 1'b0;
                    address  = {2'b00, 2'd0};
                    data_in  = 16'd3;
                    write_en = 1'b1;
                end else if (t == 7) begin
                    start    = 1'b0;
                    write_en = 1'b0;
                end else if (t == 8) begin
                    address = {2'b10, 2'd0};
                end else if (t == 9) begin
                    check("read C while busy", 32'(data_out), 32'd0);
                end
            end
            @(posedge clk);
            #1;
        end
    endtask

    int          lat;
    int          bcnt;
    int          dcnt;
    logic [15:0] v;

    initial begin
        resetn   = 1'b0;
        start    = 1'b0;
        mode     = 1'b0;
        address  = '0;
        data_in  = '0;
        write_en = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset busy", 32'(busy), 32'd0);
        check("reset done", 32'(done), 32'd0);
        check("reset data_out", 32'(data_out), 32'd0);
        resetn = 1'b1;

        // Identity secret, overwrite mode.
        load4(2'b00, 16'd1, 16'd0, 16'd0, 16'd0);
        load4(2'b01, 16'd5, 16'd6, 16'd7, 16'd8);
        run(1'b0, 1'b0, lat, bcnt, dcnt);
        check("overwrite latency", 32'(lat), 32'd21);
        check("overwrite busy cycles", 32'(bcnt), 32'd20);
        check("overwrite done pulses", 32'(dcnt), 32'd1);
        check_c("identity", 16'd5, 16'd6, 16'd7, 16'd8);

        // Multiplying by x rotates B and negates the wrapped term.
        load4(2'b00, 16'd0, 16'd1, 16'd0, 16'd0);
        load4(2'b01, 16'd1, 16'd2, 16'd3, 16'd4);
        run(1'b0, 1'b0, lat, bcnt, dcnt);
        check_c("negacyclic", 16'd8188, 16'd1, 16'd2, 16'd3);

        // Signed secret: -1 * 3 = -3 mod 8192.
        load4(2'b00, 16'h000F, 16'd0, 16'd0, 16'd0);
        load4(2'b01, 16'd3, 16'd0, 16'd0, 16'd0);
        run(1'b0, 1'b0, lat, bcnt, dcnt);
        rd(2'b10, 2'd0, v);
        check("signed C[0]", 32'(v), 32'd8189);
        rd(2'b10, 2'd1, v);
        check("signed C[1]", 32'(v), 32'd0);

        // Modular wrap: 2 * 8191 = 16382 = 8190 mod 8192.
        wr(2'b00, 2'd0, 16'd2);
        wr(2'b01, 2'd0, 16'd8191);
        run(1'b0, 1'b0, lat, bcnt, dcnt);
        rd(2'b10, 2'd0, v);
        check("modwrap C[0]", 32'(v), 32'd8190);

        // Accumulate onto a preloaded C.
        load4(2'b10, 16'd10, 16'd0, 16'd0, 16'd0);
        load4(2'b00, 16'd1, 16'd0, 16'd0, 16'd0);
        load4(2'b01, 16'd1, 16'd1, 16'd1, 16'd1);
        run(1'b1, 1'b0, lat, bcnt, dcnt);
        check("accumulate latency", 32'(lat), 32'd17);
        check("accumulate busy cycles", 32'(bcnt), 32'd16);
        check_c("accumulate", 16'd11, 16'd1, 16'd1, 16'd1);

        // Reserved region reads as zero.
        rd(2'b11, 2'd0, v);
        check("read reserved region", 32'(v), 32'd0);

        // Start and A write mid-MAC must both be ignored.
        load4(2'b01, 16'd5, 16'd6, 16'd7, 16'd8);
        run(1'b0, 1'b1, lat, bcnt, dcnt);
        check("protocol latency", 32'(lat), 32'd21);
        check("protocol done pulses", 32'(dcnt), 32'd1);
        check_c("protocol", 16'd5, 16'd6, 16'd7, 16'd8);

        // Reset mid-MAC aborts at once; operands survive.
        @(negedge clk);
        start = 1'b1;
        mode  = 1'b0;
        @(posedge clk);
        #1;
        start   = 1'b0;
        address = {2'b10, 2'd0};
        repeat (8) @(posedge clk);
        @(negedge clk);
        resetn = 1'b0;
        @(posedge clk);
        #1;
        check("abort busy", 32'(busy), 32'd0);
        check("abort done", 32'(done), 32'd0);
        check("abort data_out", 32'(data_out), 32'd0);
        @(negedge clk);
        resetn = 1'b1;
        run(1'b0, 1'b0, lat, bcnt, dcnt);
        check("after abort latency", 32'(lat), 32'd21);
        check_c("after abort", 16'd5, 16'd6, 16'd7, 16'd8);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/poly_mac_schb_param.md
Name: poly_mac_schb_param

Overview:
Parametrised successor to the 64-coefficient schoolbook multiplier wrapper. It is a memory-mapped block with three internal coefficient memories: A (secret), B (public) and C (result). On start it computes the negacyclic product C = A*B mod (x^N+1), mod 2^QW, using one multiply-accumulate per cycle. A mode input selects overwrite (C cleared first) or accumulate (C += A*B), which is the inner-product step of matrix-vector multiplication. The host loads A and B, optionally preloads C, pulses start, waits for done, then reads C.

Parameters:
N, 64, coefficients per polynomial; power of two, >= 4
QW, 13, public/result coefficient width; arithmetic is mod 2^QW
SW, 4, secret coefficient width; two's-complement signed
DW, 16, host data bus width; DW >= QW
AW, log2(N)+2 (localparam, derived), host address width

Ports:
clk  in  1  clock, rising edge
resetn  in  1  synchronous active-low reset
start  in  1  begin operation; sampled in IDLE only
mode  in  1  0 = overwrite, 1 = accumulate; sampled together with start
address  in  AW  [AW-1:AW-2] region (00 = A, 01 = B, 10 = C, 11 = reserved); [AW-3:0] coefficient index
data_in  in  DW  write data; A uses [SW-1:0], B and C use [QW-1:0]
write_en  in  1  host write strobe
data_out  out  DW  registered read data
busy  out  1  high while computing
done  out  1  one-cycle completion pulse

Behaviour:
- Reset: state = IDLE; busy = 0, done = 0, data_out = 0. Memory arrays are not reset; their contents are retained. Reset mid-operation aborts at once and leaves C partially updated.
- Host writes (IDLE only): write_en with region 00/01/10 writes the indexed A/B/C entry, truncated to SW/QW bits. Region 11 is ignored. write_en is ignored while busy.
- Host reads: data_out is updated every cycle.
  - In IDLE with region 10: data_out = zero-extended C[index], one cycle latency.
  - Otherwise (any other region, or while busy): data_out = 0.
- FSM states: IDLE, CLEAR, MAC, FIN.
  - IDLE: start=1 -> latch mode, zero i/j counters. Go to CLEAR if mode=0, otherwise to MAC. If start and write_en arrive in the same cycle, the write is performed and the operation starts.
  - CLEAR: writes C[k] = 0 for k = 0..N-1, one entry per cycle (N cycles), then goes to MAC.
  - MAC: each cycle, with k = (i+j) mod N and p = sext(A[i]) * B[j]:
    - C[k] <= C[k] + p if i+j < N;
    - C[k] <= C[k] - p if i+j >= N;
    - result truncated to QW bits.
    - j increments every cycle; on j = N-1, j wraps to 0 and i increments.
    - After (i, j) = (N-1, N-1), go to FIN. MAC lasts N*N cycles.
  - FIN: done = 1 for exactly one cycle; busy falls in the same cycle; then IDLE.
- busy = 1 in CLEAR and MAC.
- Latency, counted from the edge that samples start to the cycle in which done is high: N + N*N + 1 cycles in overwrite mode, N*N + 1 cycles in accumulate mode.
- start while busy is ignored; no queuing.
- The product is computed at full width SW+QW, then reduced. No saturation; wrap-around mod 2^QW is required behaviour.

Decomposition:
- Shared package: region codes (REG_A, REG_B, REG_C), FSM state encoding, and a log2 helper constant function.
- One natural sub-module, schb_mac_unit: a combinational sign-extend, multiply and add/subtract with QW-bit truncation, taking (a, b, c, negate) and returning c_new.
- Memories and FSM stay in the top module.

Test Plan:
- N=4, overwrite: A=[1,0,0,0], B=[5,6,7,8] -> C=[5,6,7,8]; done exactly 21 cycles after start; busy high for 20 cycles.
- N=4, negacyclic wrap: A=[0,1,0,0], B=[1,2,3,4] -> C=[8188,1,2,3], i.e. -4 mod 2^13.
- N=4, signed secret and modular wrap: A=[0xF (-1),0,0,0], B=[3,0,0,0] -> C[0]=8189. Then A=[2,0,0,0], B=[8191,0,0,0] -> C[0]=8190.
- N=4, accumulate: preload C=[10,0,0,0], A=[1,0,0,0], B=[1,1,1,1], mode=1 -> C=[11,1,1,1]; done after 17 cycles.
- Protocol: start and write_en to A asserted mid-MAC -> both ignored; result unchanged; exactly one done pulse. Read of region 11 or during busy -> data_out = 0.
- resetn low mid-MAC -> next cycle busy = 0, done = 0, data_out = 0. A and B retained; a fresh overwrite run then yields the correct C.
